// File: rtl/seg7_pkg.sv
// Shared constants and the hex-to-segment table for the multiplexed 7-segment scanner.
// Segment vectors are ordered {g,f,e,d,c,b,a} and active-low.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic       AN_OFF    = 1'b1;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low {g..a} segment pattern.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = hex_to_seg(hex);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scanner: steps one digit per rising edge of the divided scan clock,
// which is sampled as data in the clk_in domain. The displayed value only changes at frame wrap.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic                  scan_clk,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic                  data_valid,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_done
);

    localparam int             IW       = $clog2(DIGITS);
    localparam logic [IW-1:0]  LAST_IDX = IW'(DIGITS - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   tick;
    logic                   wrap;

    logic [IW-1:0]          index_q;
    logic [4*DIGITS-1:0]    pending_data_q;
    logic [DIGITS-1:0]      pending_dp_q;
    logic [4*DIGITS-1:0]    display_data_q;
    logic [DIGITS-1:0]      display_dp_q;

    logic [IW-1:0]          msn;
    logic [3:0]             cur_nibble;
    logic [6:0]             cur_seg;
    logic                   blank;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], scan_clk};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign tick = sync_q[SYNC_STAGES-1] & ~hist_q;
    assign wrap = tick && (index_q == LAST_IDX);

    // A strobe landing on the wrapping tick bypasses pending so it is not lost for a frame.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            index_q        <= '0;
            frame_done     <= 1'b0;
            pending_data_q <= '0;
            pending_dp_q   <= '0;
            display_data_q <= '0;
            display_dp_q   <= '0;
        end else begin
            frame_done <= wrap;
            if (tick) begin
                index_q <= wrap ? '0 : index_q + IW'(1);
            end
            if (data_valid) begin
                pending_data_q <= data_in;
                pending_dp_q   <= dp_in;
            end
            if (wrap) begin
                display_data_q <= data_valid ? data_in : pending_data_q;
                display_dp_q   <= data_valid ? dp_in   : pending_dp_q;
            end
        end
    end

    always_comb begin
        msn = '0;
        for (int k = 1; k < DIGITS; k++) begin
            if (display_data_q[4*k +: 4] != 4'h0) begin
                msn = IW'(k);
            end
        end
    end

    assign cur_nibble = display_data_q[{index_q, 2'b00} +: 4];
    assign blank      = blank_lz && (index_q > msn);

    seg7_hex_decode u_decode (
        .hex (cur_nibble),
        .seg (cur_seg)
    );

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            an  <= {DIGITS{AN_OFF}};
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else if (blank) begin
            an  <= {DIGITS{AN_OFF}};
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= ~(DIGITS'(1) << index_q);
            seg <= cur_seg;
            dp  <= ~display_dp_q[index_q];
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed, table-driven bench for seg7_scan_driver (DIGITS = 8, SYNC_STAGES = 2).
module tb_seg7_scan_driver;

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
    } vec_t;

    logic        clk_in = 1'b0;
    logic        rst;
    logic        scan_clk;
    logic [31:0] data_in;
    logic        data_valid;
    logic [7:0]  dp_in;
    logic        blank_lz;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_idx  = 0;
    int fd_count = 0;

    vec_t scan_tab[8];
    vec_t blank_tab[8];

    seg7_scan_driver #(.DIGITS(8), .SYNC_STAGES(2)) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .scan_clk   (scan_clk),
        .data_in    (data_in),
        .data_valid (data_valid),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    // clock / reset
    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (!rst && frame_done) fd_count++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_digit(input string name, input vec_t v);
        check({name, ".an"},  32'(an),  32'(v.an));
        check({name, ".seg"}, 32'(seg), 32'(v.seg));
        check({name, ".dp"},  32'(dp),  32'(v.dp));
    endtask

    // driver tasks; every task returns 1 time unit after a rising clk_in edge
    task automatic strobe(input logic [31:0] d, input logic [7:0] p);
        data_in    = d;
        dp_in      = p;
        data_valid = 1'b1;
        @(posedge clk_in); #1;
        data_valid = 1'b0;
    endtask

    task automatic tick(input bit with_strobe, input logic [31:0] d, input logic [7:0] p);
        scan_clk = 1'b1;
        @(posedge clk_in); #1;
        @(posedge clk_in); #1;
        if (with_strobe) begin
            data_in    = d;
            dp_in      = p;
            data_valid = 1'b1;
        end
        @(posedge clk_in); #1;
        data_valid = 1'b0;
        scan_clk   = 1'b0;
        repeat (3) begin
            @(posedge clk_in); #1;
        end
        exp_idx = (exp_idx == 7) ? 0 : exp_idx + 1;
    endtask

    task automatic run_to(input int target);
        do begin
            tick(1'b0, 32'h0, 8'h0);
        end while (exp_idx != target);
    endtask

    // Raise scan_clk and count clk_in edges until an shows the next digit.
    task automatic measure_latency(input string name);
        logic [7:0] next_an;
        int         lat;
        bit         seen;
        next_an = ~(8'(1) << ((exp_idx + 1) % 8));
        seen    = 1'b0;
        lat     = 0;
        scan_clk = 1'b1;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(posedge clk_in); #1;
            lat = k;
            if (an === next_an) seen = 1'b1;
        end
        check({name, ".latency"}, 32'(lat), 32'(4));
        exp_idx = (exp_idx + 1) % 8;
        repeat (100) begin
            @(posedge clk_in); #1;
        end
        check({name, ".hold_an"}, 32'(an), 32'(next_an));
        scan_clk = 1'b0;
        repeat (6) begin
            @(posedge clk_in); #1;
        end
        check({name, ".low_an"}, 32'(an), 32'(next_an));
    endtask

    initial begin
        // 32'h1234ABCD with dp_in 8'h05: digits 0 and 2 have the point on
        scan_tab[0] = '{8'hFE, 7'h21, 1'b0};
        scan_tab[1] = '{8'hFD, 7'h46, 1'b1};
        scan_tab[2] = '{8'hFB, 7'h03, 1'b0};
        scan_tab[3] = '{8'hF7, 7'h08, 1'b1};
        scan_tab[4] = '{8'hEF, 7'h19, 1'b1};
        scan_tab[5] = '{8'hDF, 7'h30, 1'b1};
        scan_tab[6] = '{8'hBF, 7'h24, 1'b1};
        scan_tab[7] = '{8'h7F, 7'h79, 1'b1};
        // 32'h00000500 with leading-zero blanking
        blank_tab[0] = '{8'hFE, 7'h40, 1'b1};
        blank_tab[1] = '{8'hFD, 7'h40, 1'b1};
        blank_tab[2] = '{8'hFB, 7'h12, 1'b1};
        for (int i = 3; i < 8; i++) blank_tab[i] = '{8'hFF, 7'h7F, 1'b1};

        rst        = 1'b1;
        scan_clk   = 1'b0;
        data_in    = '0;
        data_valid = 1'b0;
        dp_in      = '0;
        blank_lz   = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        check("reset.an",  32'(an),  32'hFF);
        check("reset.seg", 32'(seg), 32'h7F);
        check("reset.dp",  32'(dp),  32'h1);
        check("reset.fd",  32'(frame_done), 32'h0);
        rst = 1'b0;
        @(posedge clk_in); #1;
        check("idle.an", 32'(an), 32'hFE);

        // scan two frames
        strobe(32'h1234ABCD, 8'h05);
        fd_count = 0;
        run_to(0);
        check("scan.fd_frame1", 32'(fd_count), 32'd1);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick(1'b0, 32'h0, 8'h0);
            check_digit($sformatf("scan.d%0d", i), scan_tab[i]);
        end
        check("scan.fd_midframe", 32'(fd_count), 32'd1);

        // tear-free update mid-frame
        run_to(3);
        strobe(32'hFFFFFFFF, 8'hFF);
        for (int i = 3; i < 8; i++) begin
            if (i > 3) tick(1'b0, 32'h0, 8'h0);
            check_digit($sformatf("tear.d%0d", i), scan_tab[i]);
        end
        tick(1'b0, 32'h0, 8'h0);
        check_digit("tear.new_d0", '{8'hFE, 7'h0E, 1'b0});
        check("tear.fd_count", 32'(fd_count), 32'd3);

        // strobe coinciding with the wrapping tick
        run_to(7);
        tick(1'b1, 32'h00000007, 8'h00);
        check_digit("bypass.d0", '{8'hFE, 7'h78, 1'b1});
        run_to(1);
        check_digit("bypass.d1", '{8'hFD, 7'h40, 1'b1});
        run_to(0);
        check_digit("bypass.pending_d0", '{8'hFE, 7'h78, 1'b1});

        // leading-zero blanking
        blank_lz = 1'b1;
        strobe(32'h00000500, 8'h00);
        run_to(0);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick(1'b0, 32'h0, 8'h0);
            check_digit($sformatf("blank.d%0d", i), blank_tab[i]);
        end
        strobe(32'h00000000, 8'h00);
        run_to(0);
        check_digit("blank.zero_d0", '{8'hFE, 7'h40, 1'b1});
        tick(1'b0, 32'h0, 8'h0);
        check_digit("blank.zero_d1", '{8'hFF, 7'h7F, 1'b1});
        blank_lz = 1'b0;

        // reset mid-scan at index 5
        strobe(32'h1234ABCD, 8'h05);
        run_to(0);
        run_to(5);
        check_digit("prerst.d5", scan_tab[5]);
        rst = 1'b1;
        @(posedge clk_in); #1;
        check("midrst.an",  32'(an),  32'hFF);
        check("midrst.seg", 32'(seg), 32'h7F);
        check("midrst.dp",  32'(dp),  32'h1);
        check("midrst.fd",  32'(frame_done), 32'h0);
        rst     = 1'b0;
        exp_idx = 0;
        @(posedge clk_in); #1;
        check_digit("postrst.d0", '{8'hFE, 7'h40, 1'b1});
        tick(1'b0, 32'h0, 8'h0);
        check_digit("postrst.d1", '{8'hFD, 7'h40, 1'b1});

        // stall and edge-to-output latency
        measure_latency("lat1");
        measure_latency("lat2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
